// File: rtl/move_permit_scanner_pkg.sv
// Shared definitions for the move permit scanner: direction codes,
// scanner FSM states and the flat grid index helper.
package move_permit_scanner_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } scan_state_e;

  // Flat bit position of (direction d, scroll s, lane l) in the enable vector.
  function automatic int cell_idx(input int d, input int s, input int l,
                                  input int lanes, input int scrolls);
    return d * lanes * scrolls + s * lanes + l;
  endfunction

endpackage

// File: rtl/move_permit_scanner_step_and.sv
// Masked AND across the lanes of one scroll step: a cell that does not
// participate (mask 0) never blocks the step.
module scroll_step_and #(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0] en_i,
  input  logic [LANES-1:0] mask_i,
  output logic             ok_o
);

  assign ok_o = &(en_i | ~mask_i);

endmodule

// File: rtl/move_permit_scanner.sv
// Per-direction registered all-enabled flags plus a request/response
// scanner that walks one scroll step per cycle and stops at the first
// blocked step.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE (low while rst is high and
// in the first cycle after reset release); resp_valid and all resp_* fields
// stay stable from assertion until the edge where resp_ready is seen high.
module move_permit_scanner
  import move_permit_scanner_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int SCROLLS = 6,
  parameter int NDIR    = 4,
  parameter int DIRW    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NDIR*LANES*SCROLLS-1:0] dir_enable,
  input  logic [LANES*SCROLLS-1:0]     cell_mask,
  output logic [NDIR-1:0]              enable_o,
  input  logic                         req_valid,
  input  logic [DIRW-1:0]              req_dir,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic                         resp_grant,
  output logic [DIRW-1:0]              resp_dir,
  output logic [$clog2(SCROLLS)-1:0]   resp_fail_scroll,
  input  logic                         resp_ready,
  output logic [1:0]                   state_dbg_o
);

  localparam int              CELLS  = LANES * SCROLLS;
  localparam int              SW     = $clog2(SCROLLS);
  localparam logic [SW-1:0]   LAST_S = SW'(SCROLLS - 1);

  // ---------------- continuous all-enabled flags ----------------
  logic [NDIR*SCROLLS-1:0] step_ok;
  logic [NDIR-1:0]         enable_d;
  logic [NDIR-1:0]         enable_q;

  for (genvar d = 0; d < NDIR; d++) begin : g_dir
    for (genvar s = 0; s < SCROLLS; s++) begin : g_step
      scroll_step_and #(.LANES(LANES)) u_step (
        .en_i   (dir_enable[cell_idx(d, s, 0, LANES, SCROLLS) +: LANES]),
        .mask_i (cell_mask[cell_idx(0, s, 0, LANES, SCROLLS) +: LANES]),
        .ok_o   (step_ok[d*SCROLLS + s])
      );
    end
  end

  // A direction is enabled when every one of its scroll steps passes.
  always_comb begin
    enable_d = '0;
    for (int d = 0; d < NDIR; d++) begin
      enable_d[d] = &step_ok[d*SCROLLS +: SCROLLS];
    end
  end

  // Register the flags every cycle, independent of the scanner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) enable_q <= '0;
    else     enable_q <= enable_d;
  end

  assign enable_o = enable_q;

  // ---------------- request scanner ----------------
  scan_state_e      state_q;
  logic             rdy_q;
  logic [SW-1:0]    scan_idx_q;
  logic [CELLS-1:0] snap_en_q;
  logic [CELLS-1:0] snap_mask_q;
  logic             resp_valid_q;
  logic             resp_grant_q;
  logic [DIRW-1:0]  resp_dir_q;
  logic [SW-1:0]    resp_fail_q;

  logic             dir_in_range;
  logic [CELLS-1:0] sel_en;
  logic [CELLS-1:0] sel_mask;
  logic [LANES-1:0] scan_en;
  logic [LANES-1:0] scan_mask;
  logic             scan_ok;

  // Pick the snapshot for the requested direction; an out-of-range
  // direction gets an all-disabled, fully-masked grid so the very first
  // step fails and the request is denied at scroll 0.
  always_comb begin
    dir_in_range = int'(req_dir) < NDIR;
    sel_en       = '0;
    sel_mask     = '1;
    if (dir_in_range) begin
      sel_en   = dir_enable[int'(req_dir)*CELLS +: CELLS];
      sel_mask = cell_mask;
    end
  end

  assign scan_en   = snap_en_q[int'(scan_idx_q)*LANES +: LANES];
  assign scan_mask = snap_mask_q[int'(scan_idx_q)*LANES +: LANES];

  scroll_step_and #(.LANES(LANES)) u_scan_step (
    .en_i   (scan_en),
    .mask_i (scan_mask),
    .ok_o   (scan_ok)
  );

  // Scanner FSM: accept in IDLE, evaluate one scroll step per SCAN cycle,
  // hold the response in RESP until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b0;
      scan_idx_q   <= '0;
      snap_en_q    <= '0;
      snap_mask_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_grant_q <= 1'b0;
      resp_dir_q   <= '0;
      resp_fail_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdy_q && req_valid) begin
            snap_en_q   <= sel_en;
            snap_mask_q <= sel_mask;
            resp_dir_q  <= req_dir;
            scan_idx_q  <= '0;
            rdy_q       <= 1'b0;
            state_q     <= ST_SCAN;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!scan_ok) begin
            resp_grant_q <= 1'b0;
            resp_fail_q  <= scan_idx_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (scan_idx_q == LAST_S) begin
            resp_grant_q <= 1'b1;
            resp_fail_q  <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            rdy_q        <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready        = rdy_q;
  assign resp_valid       = resp_valid_q;
  assign resp_grant       = resp_grant_q;
  assign resp_dir         = resp_dir_q;
  assign resp_fail_scroll = resp_fail_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_move_permit_scanner.sv
// Bench for move_permit_scanner: default-parameter instance plus two
// parameter-override instances (NDIR=3, and an 8x10 grid).
module tb_move_permit_scanner;
  import move_permit_scanner_pkg::*;

  localparam int L = 4;
  localparam int S = 6;
  localparam int N = 4;
  localparam int CELLS = L * S;
  localparam int W = 12; // {grant, dir[1:0], fail[2:0], latency[5:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic [N*CELLS-1:0] dir_enable;
  logic [CELLS-1:0]   cell_mask;
  logic [N-1:0]       enable_o;
  logic               req_valid, req_ready, resp_valid, resp_grant, resp_ready;
  logic [1:0]         req_dir, resp_dir, state_dbg;
  logic [2:0]         resp_fail_scroll;

  move_permit_scanner dut (
    .clk(clk), .rst(rst), .dir_enable(dir_enable), .cell_mask(cell_mask),
    .enable_o(enable_o), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_grant(resp_grant),
    .resp_dir(resp_dir), .resp_fail_scroll(resp_fail_scroll),
    .resp_ready(resp_ready), .state_dbg_o(state_dbg)
  );

  // ---------------- NDIR=3 instance ----------------
  logic [3*CELLS-1:0] en3;
  logic [CELLS-1:0]   m3;
  logic [2:0]         enab3;
  logic               rv3, rr3, sv3, sg3, sr3;
  logic [1:0]         rd3, sd3, st3;
  logic [2:0]         sf3;

  move_permit_scanner #(.LANES(4), .SCROLLS(6), .NDIR(3), .DIRW(2)) dut_n3 (
    .clk(clk), .rst(rst), .dir_enable(en3), .cell_mask(m3), .enable_o(enab3),
    .req_valid(rv3), .req_dir(rd3), .req_ready(rr3), .resp_valid(sv3),
    .resp_grant(sg3), .resp_dir(sd3), .resp_fail_scroll(sf3),
    .resp_ready(sr3), .state_dbg_o(st3)
  );

  // ---------------- 8x10 instance ----------------
  localparam int BL = 8;
  localparam int BS = 10;
  logic [4*BL*BS-1:0] enb;
  logic [BL*BS-1:0]   mb;
  logic [3:0]         enabb;
  logic               rvb, rrb, svb, sgb, srb;
  logic [1:0]         rdb, sdb, stb;
  logic [3:0]         sfb;

  move_permit_scanner #(.LANES(BL), .SCROLLS(BS), .NDIR(4), .DIRW(2)) dut_big (
    .clk(clk), .rst(rst), .dir_enable(enb), .cell_mask(mb), .enable_o(enabb),
    .req_valid(rvb), .req_dir(rdb), .req_ready(rrb), .resp_valid(svb),
    .resp_grant(sgb), .resp_dir(sdb), .resp_fail_scroll(sfb),
    .resp_ready(srb), .state_dbg_o(stb)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  // Reference: a direction is enabled unless some participating cell is off.
  function automatic logic [N-1:0] model_enable();
    logic [N-1:0] e;
    for (int d = 0; d < N; d++) begin
      e[d] = 1'b1;
      for (int c = 0; c < CELLS; c++)
        if (cell_mask[c] && !dir_enable[d*CELLS + c]) e[d] = 1'b0;
    end
    return e;
  endfunction

  // Reference: the answer is decided by the lowest scroll column holding a
  // participating disabled cell; the scan costs one cycle per column looked
  // at, plus the accept cycle.
  function automatic logic [W-1:0] model_resp(input logic [1:0] dir);
    int first_bad = -1;
    int lat;
    for (int s = S - 1; s >= 0; s--)
      for (int l = 0; l < L; l++)
        if (cell_mask[s*L + l] && !dir_enable[int'(dir)*CELLS + s*L + l]) first_bad = s;
    if (first_bad < 0) begin
      lat = 1 + S;
      return {1'b1, dir, 3'd0, 6'(lat)};
    end
    lat = 1 + first_bad + 1;
    return {1'b0, dir, 3'(first_bad), 6'(lat)};
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_req(input logic [1:0] dir);
    for (int n = 0; n < 20 && req_ready !== 1'b1; n++) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_ready_timeout got=%b want=1", req_ready);
    end
    req_dir = dir;
    req_valid = 1'b1;
    exp_q.push_back(model_resp(dir));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Count negedges from the accept cycle until resp_valid shows up.
  task automatic collect_resp(output logic [W-1:0] obs);
    int lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    obs = {resp_grant, resp_dir, resp_fail_scroll, 6'(lat)};
  endtask

  task automatic finish_resp(input int hold);
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    dir_enable = '1; cell_mask = '1;
    en3 = '1; m3 = '1; enb = '1; mb = '1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({enable_o, req_ready, resp_valid, resp_grant, resp_dir, resp_fail_scroll} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got en=%b rdy=%b v=%b g=%b d=%0d f=%0d want all 0",
               enable_o, req_ready, resp_valid, resp_grant, resp_dir, resp_fail_scroll);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || enable_o !== 4'b1111) begin
      tests_failed++;
      $display("FAIL post_reset got rdy=%b v=%b en=%b want rdy=1 v=0 en=1111",
               req_ready, resp_valid, enable_o);
    end
  endtask

  task automatic test_all_enabled();
    logic [W-1:0] obs, e;
    dir_enable = '1; cell_mask = '1;
    @(negedge clk);
    tests_run++;
    if (enable_o !== 4'b1111) begin
      tests_failed++;
      $display("FAIL all_en_enable got=%b want=1111", enable_o);
    end
    send_req(DIR_DOWN);
    collect_resp(obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e || e !== {1'b1, DIR_DOWN, 3'd0, 6'd7}) begin
      tests_failed++;
      $display("FAIL all_en_resp got=%h want=%h", obs, e);
    end
    finish_resp(0);
  endtask

  task automatic test_cleared_bit();
    logic [W-1:0] obs, e;
    dir_enable = '1; cell_mask = '1;
    dir_enable[cell_idx(1, 3, 2, L, S)] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (enable_o !== model_enable() || enable_o !== 4'b1101) begin
      tests_failed++;
      $display("FAIL cleared_enable got=%b want=1101", enable_o);
    end
    send_req(DIR_DOWN);
    collect_resp(obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e || e !== {1'b0, DIR_DOWN, 3'd3, 6'd5}) begin
      tests_failed++;
      $display("FAIL cleared_resp got=%h want=%h", obs, e);
    end
    finish_resp(1);
    // Failure at the very first column: shortest scan.
    dir_enable = '1;
    dir_enable[cell_idx(0, 0, 0, L, S)] = 1'b0;
    send_req(DIR_UP);
    collect_resp(obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e || e !== {1'b0, DIR_UP, 3'd0, 6'd2}) begin
      tests_failed++;
      $display("FAIL step0_resp got=%h want=%h", obs, e);
    end
    finish_resp(0);
  endtask

  task automatic test_masked();
    logic [W-1:0] obs, e;
    dir_enable = '1; cell_mask = '1;
    dir_enable[cell_idx(1, 3, 2, L, S)] = 1'b0;
    cell_mask[14] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (enable_o !== model_enable() || enable_o !== 4'b1111) begin
      tests_failed++;
      $display("FAIL masked_enable got=%b want=1111", enable_o);
    end
    send_req(DIR_DOWN);
    collect_resp(obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e || e !== {1'b1, DIR_DOWN, 3'd0, 6'd7}) begin
      tests_failed++;
      $display("FAIL masked_resp got=%h want=%h", obs, e);
    end
    finish_resp(0);
  endtask

  task automatic test_snapshot_hold();
    logic [W-1:0] obs, e;
    dir_enable = '1; cell_mask = '1;
    @(negedge clk);
    send_req(DIR_RIGHT);
    dir_enable[3*CELLS +: CELLS] = '0;
    collect_resp(obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e || e[W-1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL snapshot_resp got=%h want=%h", obs, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
          {resp_grant, resp_dir, resp_fail_scroll} !== e[W-1:6]) begin
        tests_failed++;
        $display("FAIL hold_stable cycle=%0d got v=%b rdy=%b f=%h want v=1 rdy=0 f=%h",
                 i, resp_valid, req_ready, {resp_grant, resp_dir, resp_fail_scroll}, e[W-1:6]);
      end
    end
    tests_run++;
    if (enable_o !== model_enable() || enable_o[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL snapshot_enable got=%b want=%b", enable_o, model_enable());
    end
    finish_resp(0);
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [W-1:0] obs, e;
    int seen;
    dir_enable = '1; cell_mask = '1;
    @(negedge clk);
    send_req(DIR_LEFT);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    void'(exp_q.pop_front());
    tests_run++;
    if (resp_valid !== 1'b0 || enable_o !== 4'b0000 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_scan_reset got v=%b en=%b rdy=%b want 0 0000 0",
               resp_valid, enable_o, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL dropped_request got=%0d responses want=0", seen);
    end
    send_req(DIR_LEFT);
    collect_resp(obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e || e !== {1'b1, DIR_LEFT, 3'd0, 6'd7}) begin
      tests_failed++;
      $display("FAIL after_reset_resp got=%h want=%h", obs, e);
    end
    finish_resp(0);
  endtask

  task automatic test_back_to_back();
    int n;
    dir_enable = '1; cell_mask = '1;
    for (int n0 = 0; n0 < 20 && req_ready !== 1'b1; n0++) @(negedge clk);
    req_dir = DIR_LEFT; req_valid = 1'b1; resp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (resp_valid !== 1'b1 && n < 40);
      tests_run++;
      if (n != 7 || resp_grant !== 1'b1 || resp_dir !== DIR_LEFT) begin
        tests_failed++;
        $display("FAIL b2b_resp k=%0d got lat=%0d g=%b d=%0d want lat=7 g=1 d=2",
                 k, n, resp_grant, resp_dir);
      end
      if (k == 1) req_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_idle k=%0d got v=%b rdy=%b want v=0 rdy=1", k, resp_valid, req_ready);
      end
    end
    resp_ready = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) n++;
    end
    tests_run++;
    if (n != 0) begin
      tests_failed++;
      $display("FAIL b2b_extra_accept got=%0d busy cycles want=0", n);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] obs, e;
    logic [1:0] dir;
    for (int i = 0; i < 30; i++) begin
      for (int b = 0; b < N*CELLS; b++) dir_enable[b] = ($urandom_range(0, 31) != 0);
      for (int c = 0; c < CELLS; c++) cell_mask[c] = $urandom_range(0, 1) == 1;
      @(negedge clk);
      tests_run++;
      if (enable_o !== model_enable()) begin
        tests_failed++;
        $display("FAIL rand_enable it=%0d got=%b want=%b", i, enable_o, model_enable());
      end
      dir = 2'($urandom_range(0, 3));
      send_req(dir);
      collect_resp(obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL rand_resp it=%0d got=%h want=%h", i, obs, e);
      end
      finish_resp($urandom_range(0, 3));
    end
  endtask

  task automatic test_overrides();
    int n;
    // NDIR=3: direction code 3 is out of range -> denied at once.
    @(negedge clk);
    tests_run++;
    if (enab3 !== 3'b111) begin
      tests_failed++;
      $display("FAIL n3_enable got=%b want=111", enab3);
    end
    for (int n0 = 0; n0 < 20 && rr3 !== 1'b1; n0++) @(negedge clk);
    rd3 = 2'd3; rv3 = 1'b1;
    @(negedge clk);
    rv3 = 1'b0;
    n = 1;
    while (sv3 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (n != 2 || sg3 !== 1'b0 || sd3 !== 2'd3 || sf3 !== 3'd0) begin
      tests_failed++;
      $display("FAIL n3_bad_dir got lat=%0d g=%b d=%0d f=%0d want lat=2 g=0 d=3 f=0",
               n, sg3, sd3, sf3);
    end
    sr3 = 1'b1; @(negedge clk); sr3 = 1'b0;
    // 8x10 grid: full grant, then a fault in the last column.
    tests_run++;
    if (enabb !== 4'b1111) begin
      tests_failed++;
      $display("FAIL big_enable got=%b want=1111", enabb);
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) enb[cell_idx(2, BS-1, BL-1, BL, BS)] = 1'b0;
      for (int n0 = 0; n0 < 20 && rrb !== 1'b1; n0++) @(negedge clk);
      rdb = DIR_LEFT; rvb = 1'b1;
      @(negedge clk);
      rvb = 1'b0;
      n = 1;
      while (svb !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      tests_run++;
      if (n != BS + 1 || sgb !== (k == 0) || sdb !== DIR_LEFT ||
          sfb !== ((k == 0) ? 4'd0 : 4'(BS-1))) begin
        tests_failed++;
        $display("FAIL big_resp k=%0d got lat=%0d g=%b d=%0d f=%0d want lat=%0d g=%0d f=%0d",
                 k, n, sgb, sdb, sfb, BS + 1, (k == 0), (k == 0) ? 0 : BS - 1);
      end
      srb = 1'b1; @(negedge clk); srb = 1'b0;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    dir_enable = '0; cell_mask = '0; req_valid = 1'b0; req_dir = '0; resp_ready = 1'b0;
    en3 = '0; m3 = '0; rv3 = 1'b0; rd3 = '0; sr3 = 1'b0;
    enb = '0; mb = '0; rvb = 1'b0; rdb = '0; srb = 1'b0;
    test_reset();
    test_all_enabled();
    test_cleared_bit();
    test_masked();
    test_snapshot_hold();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    test_overrides();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/move_permit_scanner.md
Name: move_permit_scanner

Overview:
- Parametrised successor to the combinational per-direction enable reducer in the playfield movement path.
- Holds a LANES x SCROLLS grid of per-cell enables for each of NDIR directions.
- Continuously outputs a registered all-enabled flag per direction, honouring a cell mask.
- Also serves move requests from the game controller through a valid/ready handshake, using a sequential, early-terminating scan that returns grant or deny.

Parameters:
- LANES, 4, cells per scroll step (row count).
- SCROLLS, 6, scroll steps (column count); scan length.
- NDIR, 4, number of directions; encoding 0=up 1=down 2=left 3=right.
- DIRW, 2, width of direction code; must satisfy 2**DIRW >= NDIR.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- dir_enable  in  NDIR*LANES*SCROLLS  per-cell enables; bit d*LANES*SCROLLS + s*LANES + l = direction d, scroll s, lane l.
- cell_mask  in  LANES*SCROLLS  1 = cell participates; bit s*LANES + l.
- enable_o  out  NDIR  registered all-enabled flag per direction.
- req_valid  in  1  move request valid.
- req_dir  in  DIRW  requested direction.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  response valid.
- resp_grant  out  1  1 = move permitted.
- resp_dir  out  DIRW  echo of the accepted request's direction.
- resp_fail_scroll  out  $clog2(SCROLLS)  first scroll step that failed; 0 on grant.
- resp_ready  in  1  consumer accepts response.

Behaviour:
- Reset (async assert, sync deassert via clk edge): enable_o=0, req_ready=0 while rst high, state=IDLE, resp_valid=0, resp_grant=0, resp_dir=0, resp_fail_scroll=0, scan index=0.
- enable_o[d] = AND over all cells of (dir_enable[d][cell] | ~cell_mask[cell]), registered, 1-cycle latency, updated every cycle regardless of FSM state. All-masked gives 1.
- FSM states: IDLE, SCAN, RESP.
- IDLE: req_ready=1.
  - On req_valid: capture the req_dir slice of dir_enable, cell_mask and req_dir into snapshot registers; scan index s=0; go to SCAN.
  - Later input changes do not affect the in-flight request.
- SCAN: one scroll step per cycle.
  - Step value ok_s = AND over l of (snap_en[s*LANES+l] | ~snap_mask[s*LANES+l]).
  - If ok_s=0: resp_grant=0, resp_fail_scroll=s, go to RESP (early termination).
  - Else if s==SCROLLS-1: resp_grant=1, resp_fail_scroll=0, go to RESP.
  - Else s=s+1.
  - Latency from accept to resp_valid: 1+k cycles, where k = failing step+1, or SCROLLS on grant. Default grant latency is 7 cycles.
- RESP: resp_valid=1 and response fields are held stable until resp_ready=1. On that edge resp_valid drops and the FSM returns to IDLE.
  - req_ready stays 0 until the cycle after the handshake; no back-to-back bypass.
- req_dir >= NDIR: accepted and immediately answered as deny with resp_fail_scroll=0, latency 2.
- resp_ready asserted outside RESP: ignored.
- req_valid held high: exactly one request accepted per IDLE visit.
- rst asserted mid-SCAN or mid-RESP: all state and outputs go to their reset values immediately; the pending request is dropped with no response.
- Scan index wrap: never exceeds SCROLLS-1 and resets to 0 on every accept.

Decomposition:
- Shared package:
  - direction constants DIR_UP/DOWN/LEFT/RIGHT.
  - FSM state enum.
  - index helper function cell_idx(d,s,l).
- One sub-module, scroll_step_and: combinational LANES-wide masked AND for one scroll step. Instantiated by the scanner datapath, and NDIR*SCROLLS times inside the enable_o reduction.

Test Plan:
- All dir_enable=1, mask all 1s, request dir=1 (down) -> resp_valid 7 cycles after accept, grant=1, resp_dir=1, fail_scroll=0. enable_o=4'b1111 one cycle after inputs settle.
- Down enable bit at scroll 3 lane 2 cleared, mask full, request down -> deny, fail_scroll=3, resp_valid 5 cycles after accept. enable_o[1]=0, others 1.
- Same cleared bit but cell_mask bit 14 (s=3,l=2) = 0 -> grant=1 with 7-cycle latency, and enable_o[1]=1.
- Accept a right request, then clear all right enables during SCAN, and hold resp_ready=0 for 5 cycles in RESP -> grant=1 from the snapshot; resp fields stable for all 5 cycles; req_ready=0 throughout; returns to IDLE after the handshake.
- Assert rst two cycles into SCAN -> resp_valid=0 and enable_o=0 within the same cycle; after release, a new left request completes normally.
- req_dir=3 with NDIR=3 (parameter override) -> deny, fail_scroll=0, latency 2; repeat with LANES=8 SCROLLS=10 for a full-grid grant at 11 cycles.
